// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg -- shared CPU data-memory definitions.
//   DMC_*        : data-memory command encodings driven by the control unit
//   wb_entry_t   : one write-buffer entry (word address + store data)
//   word_addr()  : rebuilds a byte address from a stored word address
package data_mem_ctrl_pkg;

   localparam logic [1:0] DMC_IDLE  = 2'b00;
   localparam logic [1:0] DMC_LOAD  = 2'b01;
   localparam logic [1:0] DMC_STORE = 2'b10;

   // Only the word address is kept; stores are always word-aligned in memory.
   typedef struct packed {
      logic [29:0] wa;
      logic [31:0] data;
   } wb_entry_t;

   function automatic logic [31:0] word_addr(input logic [29:0] wa);
      return {wa, 2'b00};
   endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if -- CPU MEM-stage, memory and status signals of the
// data-memory controller.
//   CPU side    : req_d_valid, dmc, daddr, dout -> ; din <-
//   memory side : mem_raddr, mem_rdata (combinational read),
//                 mem_wvalid/mem_wready/mem_waddr/mem_wdata (write handshake)
//   status      : wb_full, wb_empty, wb_count, err
// Modport slave is the controller, master is the CPU/memory environment.
interface data_mem_ctrl_if #(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          req_d_valid;
   logic [1:0]    dmc;
   logic [31:0]   daddr;
   logic [31:0]   dout;
   logic [31:0]   din;
   logic [31:0]   mem_raddr;
   logic [31:0]   mem_rdata;
   logic          mem_wvalid;
   logic          mem_wready;
   logic [31:0]   mem_waddr;
   logic [31:0]   mem_wdata;
   logic          wb_full;
   logic          wb_empty;
   logic [CW-1:0] wb_count;
   logic          err;

   modport slave (
      input  req_d_valid, dmc, daddr, dout, mem_rdata, mem_wready,
      output din, mem_raddr, mem_wvalid, mem_waddr, mem_wdata,
             wb_full, wb_empty, wb_count, err
   );

   modport master (
      output req_d_valid, dmc, daddr, dout, mem_rdata, mem_wready,
      input  din, mem_raddr, mem_wvalid, mem_waddr, mem_wdata,
             wb_full, wb_empty, wb_count, err
   );
endinterface

// File: rtl/data_mem_ctrl_store_fifo.sv
// data_mem_ctrl_store_fifo -- Store_FIFO: write-buffer storage and pointers.
//   push_i/wentry_i : enqueue an entry (caller only pushes when not full or
//                     when popping in the same cycle)
//   pop_i           : dequeue head (caller only pops when not empty)
//   head_o          : oldest entry
//   slots_o         : raw storage, indexed physically, for forwarding search
//   rd_idx_o        : physical index of the head
//   count_o/full_o/empty_o : occupancy
module data_mem_ctrl_store_fifo
   import data_mem_ctrl_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  wb_entry_t              wentry_i,
   output wb_entry_t              head_o,
   output wb_entry_t [DEPTH-1:0]  slots_o,
   output logic [AW-1:0]          rd_idx_o,
   output logic [CW-1:0]          count_o,
   output logic                   full_o,
   output logic                   empty_o
);

   // Pointers carry one extra bit so full and empty differ at equal indices.
   logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
   wb_entry_t [DEPTH-1:0] slots_q;

   assign wr_ptr_d = push_i ? wr_ptr_q + CW'(1) : wr_ptr_q;
   assign rd_ptr_d = pop_i  ? rd_ptr_q + CW'(1) : rd_ptr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Data storage is not reset; stale slots are never visible past count.
   always_ff @(posedge clk) begin
      if (push_i) slots_q[wr_ptr_q[AW-1:0]] <= wentry_i;
   end

   assign count_o  = wr_ptr_q - rd_ptr_q;
   assign full_o   = (count_o == CW'(DEPTH));
   assign empty_o  = (count_o == '0);
   assign rd_idx_o = rd_ptr_q[AW-1:0];
   assign head_o   = slots_q[rd_ptr_q[AW-1:0]];
   assign slots_o  = slots_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl -- CPU data-memory controller with a posted store buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : data_mem_ctrl_if.slave (CPU request, combinational memory
//                read, write handshake to memory, buffer status, sticky err)
// Stores are queued word-aligned and drained in order; loads read memory
// combinationally, overridden by the youngest matching buffered store.
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   data_mem_ctrl_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic                  store, pop, push, full, empty;
   logic                  err_q, err_d;
   logic [AW-1:0]         rd_idx, fwd_idx;
   logic [CW-1:0]         count;
   logic [31:0]           fwd_data;
   wb_entry_t             head, wentry;
   wb_entry_t [DEPTH-1:0] slots;

   assign store  = bus.req_d_valid && (bus.dmc == DMC_STORE);
   assign pop    = !empty && bus.mem_wready;
   // A full buffer still accepts a store when its head leaves in that cycle.
   assign push   = store && (!full || pop);
   assign wentry = '{wa: bus.daddr[31:2], data: bus.dout};

   assign err_d = err_q
                | (store && (bus.daddr[1:0] != 2'b00))
                | (store && full && !pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   data_mem_ctrl_store_fifo #(.DEPTH(DEPTH)) u_store_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_i   (push),
      .pop_i    (pop),
      .wentry_i (wentry),
      .head_o   (head),
      .slots_o  (slots),
      .rd_idx_o (rd_idx),
      .count_o  (count),
      .full_o   (full),
      .empty_o  (empty)
   );

   // Walk live entries oldest to youngest so the last hit wins. The head
   // being popped this cycle is still live here (count not yet updated).
   always_comb begin
      fwd_data = bus.mem_rdata;
      fwd_idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         fwd_idx = rd_idx + AW'(k);
         if ((CW'(k) < count) && (slots[fwd_idx].wa == bus.daddr[31:2]))
            fwd_data = slots[fwd_idx].data;
      end
   end

   assign bus.din        = fwd_data;
   assign bus.mem_raddr  = bus.daddr;
   assign bus.mem_wvalid = !empty;
   assign bus.mem_waddr  = word_addr(head.wa);
   assign bus.mem_wdata  = head.data;
   assign bus.wb_full    = full;
   assign bus.wb_empty   = empty;
   assign bus.wb_count   = count;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl -- self-checking bench for data_mem_ctrl (DEPTH=4).
// A queue-based reference model tracks buffer contents and err; a directed
// vector table, hand sequences and a random phase are checked against it.
module tb_data_mem_ctrl;
   import data_mem_ctrl_pkg::*;

   localparam int DEPTH = 4;
   localparam logic [1:0] ID = 2'b00, LD = 2'b01, ST = 2'b10, RS = 2'b11;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   data_mem_ctrl_if #(.DEPTH(DEPTH)) bus();
   data_mem_ctrl #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } ment_t;
   ment_t mq[$];
   bit    m_err;

   // inputs of the cycle currently applied
   bit          c_v, c_wr;
   logic [1:0]  c_c;
   logic [31:0] c_a, c_d;

   typedef struct {
      bit v; logic [1:0] c; logic [31:0] a; logic [31:0] d; bit wr; logic [31:0] rd;
      logic [31:0] e_din; bit e_wv; logic [31:0] e_waddr; logic [31:0] e_wdata;
      int e_cnt; bit e_err;
   } vec_t;
   vec_t tbl[14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_fwd(input logic [31:0] addr, input logic [31:0] rd);
      logic [31:0] r;
      r = rd;
      foreach (mq[i]) if (mq[i].a[31:2] == addr[31:2]) r = mq[i].d;
      return r;
   endfunction

   // Drive one cycle's inputs after the falling edge and check all outputs
   // against the model (state as of the last rising edge).
   task automatic apply(input bit v, input logic [1:0] c, input logic [31:0] a,
                        input logic [31:0] d, input bit wr, input logic [31:0] rd);
      @(negedge clk);
      c_v = v; c_c = c; c_a = a; c_d = d; c_wr = wr;
      bus.req_d_valid = v; bus.dmc = c; bus.daddr = a; bus.dout = d;
      bus.mem_wready = wr; bus.mem_rdata = rd;
      #1;
      chk("din",    bus.din, m_fwd(a, rd));
      chk("raddr",  bus.mem_raddr, a);
      chk("wvalid", 32'(bus.mem_wvalid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk("waddr", bus.mem_waddr, mq[0].a);
         chk("wdata", bus.mem_wdata, mq[0].d);
      end
      chk("count",  32'(bus.wb_count), 32'(mq.size()));
      chk("full",   32'(bus.wb_full),  32'(mq.size() == DEPTH));
      chk("empty",  32'(bus.wb_empty), 32'(mq.size() == 0));
      chk("err",    32'(bus.err),      32'(m_err));
   endtask

   // Advance the model to what the coming rising edge should produce.
   task automatic commit();
      bit st, pp, fl;
      ment_t e;
      st = c_v && (c_c == ST);
      pp = (mq.size() != 0) && c_wr;
      fl = (mq.size() == DEPTH);
      if (st && ((c_a[1:0] != 2'b00) || (fl && !pp))) m_err = 1'b1;
      if (pp) void'(mq.pop_front());
      if (st && (!fl || pp)) begin
         e.a = {c_a[31:2], 2'b00};
         e.d = c_d;
         mq.push_back(e);
      end
   endtask

   task automatic step(input bit v, input logic [1:0] c, input logic [31:0] a,
                       input logic [31:0] d, input bit wr, input logic [31:0] rd);
      apply(v, c, a, d, wr, rd);
      commit();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.req_d_valid = 1'b0; bus.dmc = ID; bus.daddr = '0; bus.dout = '0;
      bus.mem_wready = 1'b0; bus.mem_rdata = '0;
      mq.delete();
      m_err = 1'b0;
      #2;
      chk("rst_wvalid", 32'(bus.mem_wvalid), 32'd0);
      chk("rst_count",  32'(bus.wb_count),   32'd0);
      chk("rst_empty",  32'(bus.wb_empty),   32'd1);
      chk("rst_err",    32'(bus.err),        32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1'b1, ST, 32'h100, 32'h11111111, 1'b0, 32'hDEAD0000, 32'hDEAD0000, 1'b0, 32'h0,   32'h0,        0, 1'b0};
      tbl[1]  = '{1'b1, LD, 32'h100, 32'h0,        1'b0, 32'h0BADBEEF, 32'h11111111, 1'b1, 32'h100, 32'h11111111, 1, 1'b0};
      tbl[2]  = '{1'b1, ST, 32'h200, 32'hA,        1'b0, 32'h1,        32'h1,        1'b1, 32'h100, 32'h11111111, 1, 1'b0};
      tbl[3]  = '{1'b1, ST, 32'h200, 32'hB,        1'b0, 32'h2,        32'hA,        1'b1, 32'h100, 32'h11111111, 2, 1'b0};
      tbl[4]  = '{1'b1, LD, 32'h200, 32'h0,        1'b0, 32'h3,        32'hB,        1'b1, 32'h100, 32'h11111111, 3, 1'b0};
      tbl[5]  = '{1'b1, LD, 32'h204, 32'h0,        1'b0, 32'h55,       32'h55,       1'b1, 32'h100, 32'h11111111, 3, 1'b0};
      tbl[6]  = '{1'b0, ID, 32'h100, 32'h0,        1'b1, 32'h66,       32'h11111111, 1'b1, 32'h100, 32'h11111111, 3, 1'b0};
      tbl[7]  = '{1'b0, ID, 32'h200, 32'h0,        1'b1, 32'h7,        32'hB,        1'b1, 32'h200, 32'hA,        2, 1'b0};
      tbl[8]  = '{1'b0, ID, 32'h100, 32'h0,        1'b1, 32'h8,        32'h8,        1'b1, 32'h200, 32'hB,        1, 1'b0};
      tbl[9]  = '{1'b1, ST, 32'h102, 32'hC,        1'b0, 32'h9,        32'h9,        1'b0, 32'h0,   32'h0,        0, 1'b0};
      tbl[10] = '{1'b0, ID, 32'h300, 32'h0,        1'b0, 32'h10,       32'h10,       1'b1, 32'h100, 32'hC,        1, 1'b1};
      tbl[11] = '{1'b1, LD, 32'h100, 32'h0,        1'b1, 32'h11,       32'hC,        1'b1, 32'h100, 32'hC,        1, 1'b1};
      tbl[12] = '{1'b0, ST, 32'h100, 32'hFF,       1'b0, 32'h12,       32'h12,       1'b0, 32'h0,   32'h0,        0, 1'b1};
      tbl[13] = '{1'b1, RS, 32'h100, 32'hFF,       1'b0, 32'h13,       32'h13,       1'b0, 32'h0,   32'h0,        0, 1'b1};

      do_reset();

      // directed vector table
      for (int i = 0; i < 14; i++) begin
         apply(tbl[i].v, tbl[i].c, tbl[i].a, tbl[i].d, tbl[i].wr, tbl[i].rd);
         chk($sformatf("t%0d_din", i),    bus.din, tbl[i].e_din);
         chk($sformatf("t%0d_wvalid", i), 32'(bus.mem_wvalid), 32'(tbl[i].e_wv));
         if (tbl[i].e_wv) begin
            chk($sformatf("t%0d_waddr", i), bus.mem_waddr, tbl[i].e_waddr);
            chk($sformatf("t%0d_wdata", i), bus.mem_wdata, tbl[i].e_wdata);
         end
         chk($sformatf("t%0d_count", i), 32'(bus.wb_count), 32'(tbl[i].e_cnt));
         chk($sformatf("t%0d_err", i),   32'(bus.err),      32'(tbl[i].e_err));
         commit();
      end

      // overflow: fifth store dropped, err set
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, ST, 32'h400 + 32'(4*i), 32'h50 + 32'(i), 1'b0, 32'h0);
      apply(1'b0, ID, 32'h410, 32'h0, 1'b0, 32'h77);
      chk("ovf_full",  32'(bus.wb_full),  32'd1);
      chk("ovf_count", 32'(bus.wb_count), 32'd4);
      chk("ovf_err",   32'(bus.err),      32'd1);
      chk("ovf_din",   bus.din,           32'h77);
      commit();
      for (int i = 0; i < 4; i++) begin
         apply(1'b0, ID, 32'h0, 32'h0, 1'b1, 32'h0);
         chk("ovf_drain_addr", bus.mem_waddr, 32'h400 + 32'(4*i));
         chk("ovf_drain_data", bus.mem_wdata, 32'h50 + 32'(i));
         commit();
      end
      apply(1'b0, ID, 32'h0, 32'h0, 1'b1, 32'h0);
      chk("ovf_drained", 32'(bus.mem_wvalid), 32'd0);
      commit();

      // full with simultaneous pop: store accepted, order preserved
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, ST, 32'h500 + 32'(4*i), 32'h60 + 32'(i), 1'b0, 32'h0);
      apply(1'b1, ST, 32'h510, 32'h64, 1'b1, 32'h0);
      chk("fp_full_before", 32'(bus.wb_full), 32'd1);
      chk("fp_head",        bus.mem_waddr,    32'h500);
      commit();
      apply(1'b0, ID, 32'h0, 32'h0, 1'b1, 32'h0);
      chk("fp_count", 32'(bus.wb_count), 32'd4);
      chk("fp_err",   32'(bus.err),      32'd0);
      chk("fp_head1", bus.mem_waddr,     32'h504);
      commit();
      for (int i = 2; i < 5; i++) begin
         apply(1'b0, ID, 32'h0, 32'h0, 1'b1, 32'h0);
         chk("fp_order_addr", bus.mem_waddr, 32'h500 + 32'(4*i));
         chk("fp_order_data", bus.mem_wdata, 32'h60 + 32'(i));
         commit();
      end
      apply(1'b0, ID, 32'h0, 32'h0, 1'b0, 32'h0);
      chk("fp_empty", 32'(bus.wb_empty), 32'd1);
      commit();

      // asynchronous reset mid-drain discards the buffer
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, ST, 32'h600 + 32'(4*i), 32'h70 + 32'(i), 1'b0, 32'h0);
      apply(1'b0, ID, 32'h600, 32'h0, 1'b0, 32'h99);
      chk("ar_wvalid_pre", 32'(bus.mem_wvalid), 32'd1);
      chk("ar_count_pre",  32'(bus.wb_count),   32'd3);
      #1 rst_n = 1'b0;
      #1;
      chk("ar_wvalid", 32'(bus.mem_wvalid), 32'd0);
      chk("ar_count",  32'(bus.wb_count),   32'd0);
      chk("ar_empty",  32'(bus.wb_empty),   32'd1);
      mq.delete();
      m_err = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      apply(1'b1, LD, 32'h600, 32'h0, 1'b0, 32'h12345678);
      chk("ar_load", bus.din, 32'h12345678);
      commit();

      // random traffic against the model
      do_reset();
      for (int n = 0; n < 600; n++) begin
         bit          rv, rwr;
         logic [1:0]  rc;
         logic [31:0] ra;
         rv  = ($urandom % 4) != 0;
         rc  = 2'($urandom);
         ra  = 32'h700 + (32'($urandom_range(0, 7)) << 2);
         if (($urandom % 8) == 0) ra = ra + 32'($urandom % 4);
         rwr = (n % 64 < 32) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
         step(rv, rc, ra, $urandom, rwr, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: Data_Mem_Ctrl

Interface
REQ-001 Parameter DEPTH, default 4, write-buffer entries; SHALL be a power of two, 2 to 16.
REQ-002 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 RESET  in  1  reset, asynchronous, active-low.
REQ-004 req_d_valid  in  1  CPU MEM-stage request qualifier.
REQ-005 DMC  in  2  CPU data-memory command: 00 idle, 01 load, 10 store word, 11 reserved (treated as idle).
REQ-006 Daddr  in  32  CPU byte address.
REQ-007 Dout  in  32  CPU store data.
REQ-008 Din  out  32  load data returned to CPU, same cycle.
REQ-009 mem_raddr  out  32  memory combinational read address.
REQ-010 mem_rdata  in  32  memory combinational read data.
REQ-011 mem_wvalid  out  1  write request to memory.
REQ-012 mem_wready  in  1  memory accepts write.
REQ-013 mem_waddr  out  32  write address, word-aligned.
REQ-014 mem_wdata  out  32  write data.
REQ-015 wb_full  out  1  buffer holds DEPTH entries.
REQ-016 wb_empty  out  1  buffer holds 0 entries.
REQ-017 wb_count  out  log2(DEPTH)+1  occupancy.
REQ-018 err  out  1  sticky error (overflow or misaligned store).

Function
REQ-019 Store = req_d_valid & DMC==10; load = req_d_valid & DMC==01; any other combination SHALL change no state.
REQ-020 A store SHALL be pushed into a FIFO write buffer at the rising edge with address {Daddr[31:2],2'b00} and data Dout; 1-cycle store latency to the CPU.
REQ-021 Buffer non-empty -> mem_wvalid=1, mem_waddr/mem_wdata = head entry; head SHALL pop at an edge where mem_wvalid & mem_wready.
REQ-022 mem_waddr/mem_wdata SHALL stay stable while mem_wvalid=1 and mem_wready=0.
REQ-023 mem_raddr SHALL equal Daddr at all times (combinational).
REQ-024 Load forwarding: Din SHALL equal the data of the youngest buffered entry whose address[31:2] matches Daddr[31:2]; with no match, Din = mem_rdata.
REQ-025 An entry being popped in the current cycle SHALL still be eligible for forwarding in that cycle.
REQ-026 A store pushed at edge N SHALL be visible to forwarding from cycle N+1.
REQ-027 Full with no pop in the same cycle: the store SHALL be dropped, count unchanged, err set.
REQ-028 Full with a simultaneous pop: the store SHALL be accepted; count stays DEPTH.
REQ-029 Empty: mem_wvalid=0; a push SHALL appear on mem_wvalid the following cycle (no bypass).
REQ-030 Store with Daddr[1:0]!=00 SHALL still be enqueued word-aligned and SHALL set err.
REQ-031 Read/write pointers SHALL wrap modulo DEPTH; wb_count SHALL be pointer difference with the extra bit, distinguishing full from empty.
REQ-032 err SHALL clear only on reset.

Reset
REQ-033 RESET low SHALL immediately (asynchronously) clear pointers and err: wb_count=0, wb_empty=1, wb_full=0, mem_wvalid=0.
REQ-034 Reset mid-drain SHALL discard all buffered stores; entry data storage need not be cleared.
REQ-035 Din, mem_raddr, mem_waddr, mem_wdata are don't-care during reset, except mem_wvalid=0.

Structure
REQ-036 DMC encodings (IDLE, LOAD, STORE) SHALL live as constants in the shared CPU package used by the control unit.
REQ-037 FIFO storage and pointers SHALL be one sub-module, Store_FIFO; match/priority logic SHALL stay in Data_Mem_Ctrl.

Verification
REQ-038 Store 0x11111111 to 0x100, mem_wready=0, load 0x100 next cycle -> Din=0x11111111, mem_wvalid=1, mem_waddr=0x100.
REQ-039 Stores 0xA to 0x200 then 0xB to 0x200, load 0x200 -> Din=0xB (youngest); load 0x204 -> Din=mem_rdata.
REQ-040 DEPTH=4, mem_wready=0, five stores -> wb_full=1, wb_count=4, err=1, fifth store absent from drain sequence.
REQ-041 Full buffer, mem_wready=1, store in same cycle -> accepted, wb_count=4, err=0; drain order equals issue order.
REQ-042 RESET low with 3 entries and mem_wvalid=1 -> mem_wvalid=0 and wb_count=0 before the next edge; after release, load of a previously stored address returns mem_rdata.
REQ-043 Store to 0x102 -> err=1, mem_waddr=0x100.
